// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the 16x16 shift-add multiplier.
package mult_pkg;

  localparam int MULT_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups
// whose group generate/propagate feed a second lookahead level.
module cla_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Ovfl
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] carry_in;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  assign g = A & B;
  assign p = A ^ B;

  for (genvar gi = 0; gi < 4; gi++) begin : g_group
    logic [3:0] gg;
    logic [3:0] pp;
    logic       c0;
    logic       c1;
    logic       c2;
    logic       c3;

    assign gg = g[4*gi +: 4];
    assign pp = p[4*gi +: 4];
    assign c0 = grp_c[gi];
    assign c1 = gg[0] | (pp[0] & c0);
    assign c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
    assign c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & c0);

    assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p[gi] = &pp;
    assign carry_in[4*gi +: 4] = {c3, c2, c1, c0};
  end

  // Second lookahead level: group carries depend only on Cin and group G/P.
  assign grp_c[0] = Cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & Cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & Cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & Cin);

  assign Sum  = p ^ carry_in;
  assign Cout = grp_c[4];
  assign Ovfl = carry_in[15] ^ grp_c[4];

endmodule

// File: rtl/seq_mult_16bit.sv
// Sequential unsigned 16x16 shift-add multiplier: 16 RUN steps, one DONE
// cycle with a registered 32-bit product that holds until the next result.
import mult_pkg::*;

module seq_mult_16bit (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MULT_W-1:0]     A,
  input  logic [MULT_W-1:0]     B,
  output logic                  busy,
  output logic                  done,
  output logic [2*MULT_W-1:0]   P
);

  state_t                state_q, state_d;
  logic [MULT_W-1:0]     m_q, m_d;
  logic [MULT_W-1:0]     q_q, q_d;
  logic [MULT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*MULT_W-1:0]   p_q, p_d;

  logic [MULT_W-1:0]     addend;
  logic [MULT_W-1:0]     sum;
  logic                  carry;
  logic                  cla_ovfl_unused;

  assign addend = q_q[0] ? m_q : '0;

  cla_16bit u_cla (
    .A    (acc_q),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (carry),
    .Ovfl (cla_ovfl_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_STEP) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The carry-out re-enters at the top of ACC, so no product bit is lost.
  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    if (state_q == IDLE && start) begin
      m_d   = A;
      q_d   = B;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = {carry, sum[MULT_W-1:1]};
      q_d   = {sum[0], q_q[MULT_W-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_STEP) begin
        p_d = {carry, sum[MULT_W-1:1], sum[0], q_q[MULT_W-1:1]};
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign P = p_q;

endmodule

// File: tb/tb_seq_mult_16bit.sv
// Scoreboard bench for seq_mult_16bit: stimulus pushes expected product and
// done cycle, a negedge monitor pops and compares whenever done is seen.
module tb_seq_mult_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] P;

  typedef struct {
    logic [31:0] p;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_p = '0;

  seq_mult_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      last_p   = '0;
    end else begin
      chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got P=0x%08h with no pending request (cycle %0d)", P, cyc);
        end else begin : pop_blk
          exp_t e;
          e = sb_q.pop_front();
          $display("txn P=0x%08h expected 0x%08h done_cycle=%0d expected %0d busy_cycles=%0d",
                   P, e.p, cyc, e.cyc, busy_cnt);
          chk("product", P, e.p);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, 32'd16);
          last_p = e.p;
        end
        busy_cnt = 0;
      end else begin
        chk("p_hold", P, last_p);
        if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
          checks++;
          errors++;
          $display("FAIL done_timeout: got no done by cycle %0d, required at cycle %0d", cyc, sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where done shows.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p);
    exp_t e;
    A     = a;
    B     = b;
    start = 1'b1;
    e.p   = exp_p;
    e.cyc = cyc + 17;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    repeat (16) @(negedge clk);
  endtask

  task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p);
    @(negedge clk);
    issue(a, b, exp_p);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_p", P, 32'd0);

    // Start on the very first edge after reset release.
    rst_n = 1'b1;
    issue(16'h0003, 16'h0005, 32'h0000_000F);
    do_mult(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    do_mult(16'h1234, 16'h0000, 32'h0000_0000);
    do_mult(16'h0000, 16'hABCD, 32'h0000_0000);
    do_mult(16'h8000, 16'h8000, 32'h4000_0000);
    do_mult(16'hFFFF, 16'h0001, 32'h0000_FFFF);
    do_mult(16'h0001, 16'hFFFF, 32'h0000_FFFF);
    do_mult(16'h1234, 16'h5678, 32'h0626_0060);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_mult(ra, rb, 32'(ra) * 32'(rb));
    end

    // start held high; operands disturbed during RUN; one result per 18 cycles.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      A     = 16'd7;
      B     = 16'd9;
      start = 1'b1;
      e.p   = 32'h0000_003F;
      e.cyc = cyc + 17;
      sb_q.push_back(e);
      @(negedge clk);
      A = 16'hFFFF;
      B = 16'hFFFF;
      repeat (17) @(negedge clk);
    end
    start = 1'b0;

    // Reset in the middle of RUN: no done, outputs cleared at once.
    @(negedge clk);
    A     = 16'h00FF;
    B     = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
    chk("midrun_reset_done", {31'd0, done}, 32'd0);
    chk("midrun_reset_p", P, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0002, 16'h0003, 32'h0000_0006);

    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results still pending, required 0", sb_q.size());
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
